// File: rtl/stream_mux_n.sv
// N-to-1 valid/ready stream multiplexer with fixed-select or round-robin arbitration
// feeding a single registered output slot that sustains one beat per cycle.
module stream_mux_n #(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic [SW-1:0] last_q,      last_d;

  logic          load_en_c;
  logic          grant_valid_c;
  logic [SW-1:0] grant_c;
  logic [SW-1:0] cand_c;

  assign load_en_c = !out_valid_q || out_ready;

  // Arbitration: fixed select, or first valid channel after the last granted one
  always_comb begin
    grant_c       = '0;
    grant_valid_c = 1'b0;
    cand_c        = '0;
    if (!mode) begin
      grant_c = sel;
      if (32'(sel) < N) grant_valid_c = in_valid[sel];
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        cand_c = SW'((32'(last_q) + k + 32'd1) % N);
        if (!grant_valid_c && in_valid[cand_c]) begin
          grant_c       = cand_c;
          grant_valid_c = 1'b1;
        end
      end
    end
  end

  // One-hot ready toward the granted channel; held low while in reset
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = rst_n && load_en_c && grant_valid_c && (grant_c == SW'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    if (load_en_c) begin
      out_valid_d = grant_valid_c;
      if (grant_valid_c) begin
        out_data_d = in_data[32'(grant_c)*W +: W];
        out_ch_d   = grant_c;
        if (mode) last_d = grant_c;
      end
    end
  end

  // last resets to N-1 so the first round-robin search starts at channel 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n (N=4, W=8): per-cycle transaction-level model
// plus literal expectations for the documented scenarios.
module tb_stream_mux_n;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: the beat the output slot should hold and the last round-robin winner
  bit       m_valid;
  int       m_data;
  int       m_ch;
  int       m_last;

  stream_mux_n #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel      (sel),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 0;
    m_ch    = 0;
    m_last  = N - 1;
  endtask

  // Which channel the rules say wins this cycle (-1 when none may be granted)
  function automatic int model_grant();
    int s;
    s = int'(sel);
    if (!mode) return (s < N && in_valid[s]) ? s : -1;
    for (int off = 1; off <= N; off++) begin
      if (in_valid[(m_last + off) % N]) return (m_last + off) % N;
    end
    return -1;
  endfunction

  // Check outputs against the model mid-cycle, then advance the model across one edge
  task automatic cycle();
    int  g;
    bit  may_load;
    logic [N-1:0] exp_rdy;
    logic [31:0]  din;
    #1;
    may_load = !m_valid || out_ready;
    g = model_grant();
    exp_rdy = '0;
    if (rst_n && may_load && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready",  32'(in_ready),  32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_ch",    32'(out_ch),    32'(m_ch));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (may_load) begin
      if (g >= 0) begin
        din     = in_data;
        m_valid = 1'b1;
        m_data  = int'((din >> (g * W)) & 32'hFF);
        m_ch    = g;
        if (mode) m_last = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_seq [5];
    model_reset();
    rst_n = 1'b0; mode = 1'b1; sel = '0; out_ready = 1'b1;
    in_valid = 4'hF; in_data = {8'h33, 8'h22, 8'h11, 8'h00};

    // Held in reset with inputs offered: nothing readied, nothing emitted
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;

    // Round-robin from reset, all channels valid: 0,1,2,3,0
    exp_seq[0] = 4'd0; exp_seq[1] = 4'd1; exp_seq[2] = 4'd2; exp_seq[3] = 4'd3; exp_seq[4] = 4'd0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_all_ch",    32'(out_ch),    32'(exp_seq[i]));
      chk("rr_all_valid", 32'(out_valid), 32'd1);
    end

    // Round-robin on 1010: alternates 1,3
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_1010_ch", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
      chk("rr_1010_rdy_mask", 32'(in_ready & 4'b0101), 32'd0);
    end

    // Fixed select channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("fix2_data", 32'(out_data), 32'h22);
      chk("fix2_ch",   32'(out_ch),   32'd2);
      chk("fix2_rdy",  32'(in_ready), 32'b0100);
    end

    // Backpressure: A5 from ch1 held while mode/sel/data wiggle
    sel = 2'd1; in_valid = 4'b0010; in_data = {8'h33, 8'h22, 8'hA5, 8'h00};
    cycle();
    chk("bp_load", 32'(out_data), 32'hA5);
    out_ready = 1'b0;
    in_data = {8'h33, 8'h22, 8'h5A, 8'h00};
    for (int i = 0; i < 3; i++) begin
      mode = i[0]; sel = 2'(i);
      in_valid = 4'hF;
      cycle();
      chk("bp_data",  32'(out_data),  32'hA5);
      chk("bp_ch",    32'(out_ch),    32'd1);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_rdy",   32'(in_ready),  32'd0);
    end
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010;
    out_ready = 1'b1;
    cycle();
    chk("bp_reload", 32'(out_data), 32'h5A);
    chk("bp_reload_valid", 32'(out_valid), 32'd1);

    // Fixed select on an idle channel: pending beat drains, then slot empties
    sel = 2'd3; in_valid = 4'b0111;
    cycle();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_hold",  32'(out_data),  32'h5A);
    chk("idle_rdy",   32'(in_ready),  32'd0);

    // Mixed patterns with intermittent backpressure, checked by the model
    for (int i = 0; i < 24; i++) begin
      mode      = i[0];
      sel       = 2'((i * 3) % 4);
      in_valid  = 4'((i * 7 + 3) % 16);
      out_ready = (i % 3) != 0;
      in_data   = {8'(i * 17 + 1), 8'(i * 5 + 2), 8'(i * 11 + 3), 8'(i * 13 + 4)};
      cycle();
    end

    // Reset pulse while a beat is held: dropped at once, arbitration restarts at ch0
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    in_data = {8'h33, 8'h22, 8'h11, 8'h00};
    cycle();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_rdy",   32'(in_ready),  32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    cycle();
    chk("post_rst_ch",    32'(out_ch),    32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    cycle();
    chk("post_rst_ch2", 32'(out_ch), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter W, default 8, data width per channel (1..64).
REQ-003 SHALL define SW = max(1, ceil(log2 N)), the select and channel-ID width.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port mode, input, 1 bit: 0 = fixed select, 1 = round-robin.
REQ-007 Port sel, input, SW bits: channel chosen in fixed mode.
REQ-008 Port in_valid, input, N bits: per-channel valid.
REQ-009 Port in_data, input, N*W bits: channel i occupies bits [i*W +: W].
REQ-010 Port in_ready, output, N bits: per-channel ready.
REQ-011 Port out_valid, output, 1 bit: output register holds a beat.
REQ-012 Port out_data, output, W bits: registered data.
REQ-013 Port out_ch, output, SW bits: source channel of the held beat.
REQ-014 Port out_ready, input, 1 bit: downstream accepts the beat.

Function
REQ-015 Transfer rule: an input transfer occurs on channel i when in_valid[i] and in_ready[i] are both 1 at a rising edge; an output transfer occurs when out_valid and out_ready are both 1.
REQ-016 load_en = !out_valid || out_ready; the output register loads only when load_en is 1.
REQ-017 in_ready[i] = load_en && grant_valid && (grant == i); at most one bit of in_ready is 1 per cycle.
REQ-018 in_ready SHALL NOT depend on in_data.
REQ-019 Fixed mode:
  - grant = sel and grant_valid = in_valid[sel].
  - sel >= N gives grant_valid = 0.
  - Other channels are never granted.
REQ-020 Round-robin mode:
  - grant = first i with in_valid[i] = 1, searching from (last + 1) mod N upward, wrapping from N-1 to 0.
  - grant_valid = |in_valid.
REQ-021 last SHALL update to grant only on an input transfer in round-robin mode; it is unchanged in fixed mode and on stall cycles.
REQ-022 On an input transfer: out_data <= in_data of grant, out_ch <= grant, out_valid <= 1 at the next edge (latency one cycle).
REQ-023 Output transfer with no input transfer in the same cycle: out_valid <= 0; out_data and out_ch hold their values.
REQ-024 Simultaneous output and input transfer: the register is replaced in the same cycle with no bubble, giving full throughput of one beat per cycle.
REQ-025 While out_valid = 1 and out_ready = 0: out_data, out_ch and out_valid SHALL be stable and in_ready SHALL be all 0.
REQ-026 Changes to mode and sel affect only the arbitration of the current cycle; a beat already held SHALL NOT be altered.
REQ-027 A channel with in_valid = 0 SHALL never be granted in either mode.

Reset
REQ-028 rst_n = 0 SHALL asynchronously force: out_valid = 0, out_data = 0, out_ch = 0, last = N-1.
REQ-029 During reset, in_ready SHALL be all 0.
REQ-030 After release, the first round-robin grant priority starts at channel 0; no beat is emitted before the first input transfer.
REQ-031 Reset asserted mid-transfer SHALL discard the held beat; no partial beat may be emitted after release.

Verification (N=4, W=8)
REQ-032 Fixed mode, sel=2, in_valid=4'b1111, in_data = {8'h33,8'h22,8'h11,8'h00}, out_ready=1 -> in_ready=4'b0100 every cycle; out_data=8'h22, out_ch=2 one cycle after each edge; channels 0, 1 and 3 are never readied.
REQ-033 Round-robin from reset, in_valid=4'b1111, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1 from cycle 1.
REQ-034 Round-robin, in_valid=4'b1010, out_ready=1 -> out_ch alternates 1,3,1,3; channels 0 and 2 are never readied.
REQ-035 Backpressure: beat 8'hA5 held from ch1, out_ready=0 for 3 cycles -> out_data=8'hA5, out_ch=1, out_valid=1 stable and in_ready=0; when out_ready=1 the next beat loads in the same cycle.
REQ-036 Fixed mode, sel=3, in_valid[3]=0 -> in_ready=0; out_valid falls to 0 after the pending beat drains.
REQ-037 rst_n pulsed low for half a cycle while out_valid=1 -> out_valid=0 immediately; after release the round-robin grant restarts at ch0.
